pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Fetch-stage PC generator and instruction-fetch sequencer. It replaces the combinational next-PC mux with a registered PC and a parametrised, priority-ordered set of redirect channels (exception, mispredict, jump, …). It drives a single-outstanding request/response handshake to the instruction memory and presents fetched instructions to decode with stall backpressure. Redirects that arrive while a request is in flight are buffered, and the stale response is squashed.

Parameters:
XLEN, 64, PC and address width
NUM_REDIRECT, 3, redirect channels; index 0 = highest priority (exception)
RESET_PC, 64'h8000_0000, PC after reset
ILEN, 32, instruction width returned by memory
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  NUM_REDIRECT  per-channel redirect request
redirect_pc  in  NUM_REDIRECT*XLEN  per-channel target, packed; channel i at [i*XLEN +: XLEN]
stall  in  1  decode cannot accept this cycle
ireq_valid  out  1  fetch request valid
ireq_addr  out  XLEN  fetch address
ireq_ready  in  1  memory accepts request this cycle
iresp_valid  in  1  response data valid
iresp_data  in  ILEN  fetched instruction
out_valid  out  1  instruction valid to decode
out_pc  out  XLEN  PC of out_instr
out_instr  out  ILEN  instruction to decode

Behaviour:
- Clock and reset are fixed: one clock, `clk`; reset is synchronous and active-high, on `reset`.
- States: S_RST, S_REQ, S_WAIT, S_HOLD.
- Reset values: state=S_RST, pc=RESET_PC, pend_valid=0, stale=0, instr_q=0.
- Reset takes priority over everything, in every state. iresp_valid is ignored in all states except S_WAIT.
- Outputs:
  - ireq_valid = (state==S_REQ); ireq_addr = pc.
  - out_valid = (state==S_HOLD) & ~|redirect_valid; out_pc = pc; out_instr = instr_q.
  - All outputs are 0 in S_RST, except ireq_addr/out_pc, which show pc.
- Redirect selection: the lowest-index asserted channel wins (sel_pc).
  - Across cycles, the most recent redirect overwrites any pending one.
  - Low 2 bits of the target pass through unmodified; alignment faults are checked downstream.
- S_RST: go to S_REQ on the next cycle. First ireq_valid is the cycle after reset deasserts.
- S_REQ:
  - ireq_addr is held stable until ireq_ready.
  - A redirect here sets pend_valid=1 and pend_pc=sel_pc; pc stays unchanged.
  - On ireq_ready: go to S_WAIT with stale = pend_valid | redirect this cycle.
- S_WAIT:
  - A redirect sets pend_valid and pend_pc.
  - On iresp_valid with stale, pend_valid, or a redirect this cycle: drop the data; pc <= (redirect ? sel_pc : pend_pc); clear pend_valid and stale; go to S_REQ.
  - On iresp_valid otherwise: instr_q <= iresp_data; go to S_HOLD.
  - A redirect and iresp_valid in the same cycle: the response is dropped, and the next ireq_addr = sel_pc.
- S_HOLD:
  - A redirect sets pc <= sel_pc and goes to S_REQ; out_valid is suppressed that cycle.
  - Else if ~stall: handshake completes; pc <= pc + PC_STEP (wraps modulo 2^XLEN); go to S_REQ.
  - Else hold; out_pc and out_instr stay stable.
- Latency: redirect in S_HOLD at cycle t → ireq_addr = target at t+1. Minimum sequential throughput is one instruction per 3 cycles (REQ→WAIT→HOLD) with single-cycle ready/response.

Decomposition:
- Package (common): pcgen_state_t enum (S_RST, S_REQ, S_WAIT, S_HOLD) and a PC_RESET constant; widths use existing u64/u32 aliases.
- Sub-module redirect_arbiter: parametrised NUM_REDIRECT fixed-priority encoder; outputs any_valid and sel_pc. Purely combinational.
- pc_gen contains the FSM and registers.

Test Plan:
- Reset 3 cycles then release, ireq_ready=1, iresp next cycle, stall=0 → ireq_addr 0x8000_0000 the cycle after release; out_pc 0x8000_0000 then 0x8000_0004 on successive out_valid pulses; instr matches memory model.
- ireq_ready low 4 cycles → ireq_valid stays 1 and ireq_addr stays 0x8000_0000 throughout; exactly one response is consumed.
- redirect_valid=3'b011 (ch0=0x8000_0100, ch1=0x8000_0200) in S_HOLD → out_valid=0 that cycle; next ireq_addr=0x8000_0100.
- redirect ch2=0x8000_0040 during S_WAIT, response 2 cycles later → that response never appears on out_valid; next ireq_addr=0x8000_0040.
- In S_HOLD, stall=1 for 3 cycles → out_valid, out_pc, out_instr stable; pc advances by 4 only on the first ~stall cycle.
- reset asserted in S_WAIT, iresp_valid arrives during/after reset → response ignored; next ireq_addr=0x8000_0000; pc=0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
package pc_gen_pkg;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT, S_HOLD} pcgen_state_t;
  localparam u64 PC_RESET = 64'h8000_0000;
endpackage

// File: rtl/pc_gen_redirect_arbiter.sv
// pc_gen_redirect_arbiter: fixed-priority redirect select, channel 0 wins.
module pc_gen_redirect_arbiter
  import pc_gen_pkg::*;
#(
  parameter int N    = 3,
  parameter int XLEN = 64
) (
  input  logic [N-1:0]      i_valid,
  input  logic [N*XLEN-1:0] i_pc,
  output logic              o_any_valid,
  output logic [XLEN-1:0]   o_sel_pc
);
  assign o_any_valid = |i_valid;
  always_comb begin
    o_sel_pc = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_valid[i]) o_sel_pc = i_pc[i*XLEN +: XLEN];
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered PC with prioritised redirects and a single-outstanding fetch handshake.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              NUM_REDIRECT = 3,
  parameter logic [XLEN-1:0] RESET_PC     = PC_RESET,
  parameter int              ILEN         = 32,
  parameter int              PC_STEP      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_pc,
  input  logic                         stall,
  output logic                         ireq_valid,
  output logic [XLEN-1:0]              ireq_addr,
  input  logic                         ireq_ready,
  input  logic                         iresp_valid,
  input  logic [ILEN-1:0]              iresp_data,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_pc,
  output logic [ILEN-1:0]              out_instr
);
  pcgen_state_t    r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n, r_pend_pc, w_pend_pc_n, w_sel_pc;
  logic            r_pend_valid, w_pend_valid_n, r_stale, w_stale_n, w_redir;
  logic [ILEN-1:0] r_instr_q, w_instr_n;

  pc_gen_redirect_arbiter #(.N(NUM_REDIRECT), .XLEN(XLEN)) u_arb (
    .i_valid    (redirect_valid),
    .i_pc       (redirect_pc),
    .o_any_valid(w_redir),
    .o_sel_pc   (w_sel_pc)
  );

  assign ireq_valid = (r_state == S_REQ);
  assign ireq_addr  = r_pc;
  assign out_valid  = (r_state == S_HOLD) & ~w_redir;
  assign out_pc     = r_pc;
  assign out_instr  = r_instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RST;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_stale      <= 1'b0;
      r_instr_q    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_pend_valid <= w_pend_valid_n;
      r_pend_pc    <= w_pend_pc_n;
      r_stale      <= w_stale_n;
      r_instr_q    <= w_instr_n;
    end
  end

  // While a request is outstanding, redirects are parked in pend_* and applied once the response retires.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_pend_valid_n = r_pend_valid;
    w_pend_pc_n    = r_pend_pc;
    w_stale_n      = r_stale;
    w_instr_n      = r_instr_q;
    case (r_state)
      S_RST: w_state_n = S_REQ;
      S_REQ: begin
        w_pend_valid_n = r_pend_valid | w_redir;
        w_pend_pc_n    = w_redir ? w_sel_pc : r_pend_pc;
        w_state_n      = ireq_ready ? S_WAIT : S_REQ;
        w_stale_n      = ireq_ready ? (r_pend_valid | w_redir) : r_stale;
      end
      S_WAIT: begin
        w_pend_valid_n = r_pend_valid | w_redir;
        w_pend_pc_n    = w_redir ? w_sel_pc : r_pend_pc;
        if (iresp_valid && (r_stale || r_pend_valid || w_redir)) begin
          w_pc_n         = w_redir ? w_sel_pc : r_pend_pc;
          w_pend_valid_n = 1'b0;
          w_stale_n      = 1'b0;
          w_state_n      = S_REQ;
        end else if (iresp_valid) begin
          w_instr_n = iresp_data;
          w_state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        w_pc_n    = w_redir ? w_sel_pc : (stall ? r_pc : r_pc + XLEN'(PC_STEP));
        w_state_n = (w_redir || !stall) ? S_REQ : S_HOLD;
      end
    endcase
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with hand-computed expectations.
module tb_pc_gen;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   redirect_valid = '0;
  logic [191:0] redirect_pc = '0;
  logic         stall = 1'b0;
  logic         ireq_valid, ireq_ready = 1'b0;
  logic [63:0]  ireq_addr, out_pc;
  logic         iresp_valid = 1'b0;
  logic [31:0]  iresp_data = '0, out_instr;
  logic         out_valid;
  int           n_vec = 0, n_err = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [2:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [63:0] p2);
    redirect_valid = v;
    redirect_pc    = {p2, p1, p0};
    #1;
  endtask

  // From S_REQ at addr: handshake, single-cycle response, finish in S_HOLD.
  task automatic fetch(input logic [63:0] addr);
    chk("req_valid", ireq_valid, 1);
    chk("req_addr", ireq_addr, addr);
    ireq_ready = 1'b1;
    tick;
    ireq_ready = 1'b0;
    chk("wait_req_valid", ireq_valid, 0);
    chk("wait_out_valid", out_valid, 0);
    iresp_valid = 1'b1;
    iresp_data  = mem(addr);
    tick;
    iresp_valid = 1'b0;
    chk("hold_out_valid", out_valid, 1);
    chk("hold_out_pc", out_pc, addr);
    chk("hold_out_instr", out_instr, mem(addr));
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_req_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_addr", ireq_addr, 64'h8000_0000);
    chk("rst_out_instr", out_instr, 0);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req_valid", ireq_valid, 1);
      chk("hold_req_addr", ireq_addr, 64'h8000_0000);
      tick;
    end
    fetch(64'h8000_0000);
    tick;
    chk("one_resp_out_valid", out_valid, 0);
    fetch(64'h8000_0004);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_pc", out_pc, 64'h8000_0004);
      chk("stall_out_instr", out_instr, mem(64'h8000_0004));
      chk("stall_req_valid", ireq_valid, 0);
    end
    stall = 1'b0;
    tick;
    fetch(64'h8000_0008);
    redir(3'b011, 64'h8000_0100, 64'h8000_0200, 64'h0);
    chk("hold_redir_out_valid", out_valid, 0);
    tick;
    redir(3'b000, 0, 0, 0);
    chk("hold_redir_req_valid", ireq_valid, 1);
    chk("hold_redir_addr", ireq_addr, 64'h8000_0100);
    ireq_ready = 1'b1;
    tick;
    ireq_ready = 1'b0;
    redir(3'b100, 0, 0, 64'h8000_0040);
    tick;
    redir(3'b000, 0, 0, 0);
    tick;
    iresp_valid = 1'b1;
    iresp_data  = 32'hDEAD_BEEF;
    #1;
    chk("wait_squash_out_valid", out_valid, 0);
    tick;
    iresp_valid = 1'b0;
    chk("squash_out_valid", out_valid, 0);
    chk("squash_addr", ireq_addr, 64'h8000_0040);
    fetch(64'h8000_0040);
    tick;
    redir(3'b010, 0, 64'h8000_0300, 0);
    tick;
    redir(3'b000, 0, 0, 0);
    chk("req_redir_addr_held", ireq_addr, 64'h8000_0044);
    ireq_ready = 1'b1;
    tick;
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    tick;
    iresp_valid = 1'b0;
    chk("pend_out_valid", out_valid, 0);
    chk("pend_addr", ireq_addr, 64'h8000_0300);
    ireq_ready = 1'b1;
    tick;
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    redir(3'b110, 0, 64'h8000_0500, 64'h8000_0600);
    tick;
    iresp_valid = 1'b0;
    redir(3'b000, 0, 0, 0);
    chk("same_cycle_out_valid", out_valid, 0);
    chk("same_cycle_addr", ireq_addr, 64'h8000_0500);
    ireq_ready = 1'b1;
    tick;
    ireq_ready  = 1'b0;
    reset       = 1'b1;
    iresp_valid = 1'b1;
    tick;
    chk("wait_rst_req_valid", ireq_valid, 0);
    chk("wait_rst_out_valid", out_valid, 0);
    reset = 1'b0;
    tick;
    iresp_valid = 1'b0;
    chk("post_rst_out_valid", out_valid, 0);
    fetch(64'h8000_0000);
    redir(3'b001, 64'h8000_0003, 0, 0);
    chk("odd_redir_out_valid", out_valid, 0);
    tick;
    redir(3'b000, 0, 0, 0);
    chk("odd_addr", ireq_addr, 64'h8000_0003);
    ireq_ready = 1'b1;
    redir(3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    tick;
    ireq_ready = 1'b0;
    redir(3'b000, 0, 0, 0);
    iresp_valid = 1'b1;
    tick;
    iresp_valid = 1'b0;
    chk("req_ready_redir_out_valid", out_valid, 0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC);
    tick;
    chk("wrap_addr", ireq_addr, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
